// File: rtl/piezo_seq_pkg.sv
// Shared types, tune tables and timing constants for the piezo alert sequencer.
package piezo_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int HP_W  = 15;
    localparam int DUR_W = 26;
    localparam int REP_W = 28;

    typedef struct packed {
        logic [HP_W-1:0]  half_period;
        logic [DUR_W-1:0] duration;
    } note_t;

    localparam int FAST_INC         = 64;
    localparam int REPEAT_CLKS_FAST = 2_343_744;

    function automatic int timer_inc(input int fast_sim);
        return (fast_sim != 0) ? FAST_INC : 1;
    endfunction

    function automatic int tune_len(input int alert);
        case (alert)
            0:       return 2;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic note_t mk_note(input int hp, input int dur);
        note_t n;
        n.half_period = HP_W'(hp);
        n.duration    = DUR_W'(dur);
        return n;
    endfunction

    // Values are in real clocks; alerts beyond the table reuse the lowest-priority tune.
    function automatic note_t tune_note(input int alert, input int idx);
        note_t n;
        n = mk_note(384, 1280);
        case (alert)
            0: begin
                case (idx)
                    0:       n = mk_note(384, 3840);
                    default: n = mk_note(640, 3840);
                endcase
            end
            1: begin
                case (idx)
                    0:       n = mk_note(512, 2560);
                    1:       n = mk_note(768, 2560);
                    default: n = mk_note(700, 1900);
                endcase
            end
            default: begin
                case (idx)
                    0:       n = mk_note(384, 1280);
                    1:       n = mk_note(512, 1280);
                    2:       n = mk_note(640, 1280);
                    default: n = mk_note(768, 1280);
                endcase
            end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/piezo_seq_tone_gen.sv
// Half-period counter that toggles the tone; clr restarts the note with the tone low.
module piezo_tone_gen
    import piezo_seq_pkg::*;
#(
    parameter int INC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    input  logic [HP_W-1:0] half_period,
    output logic            tone
);

    logic [HP_W-1:0] r_cnt;
    logic            r_tone;
    logic [HP_W:0]   w_next;

    assign w_next = {1'b0, r_cnt} + (HP_W+1)'(INC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (en) begin
            // >= so an overshooting fast-sim step still lands on the boundary
            if (w_next >= {1'b0, half_period}) begin
                r_cnt  <= '0;
                r_tone <= ~r_tone;
            end else begin
                r_cnt <= w_next[HP_W-1:0];
            end
        end
    end

    assign tone = r_tone;

endmodule

// File: rtl/piezo_seq.sv
// Priority alert tune sequencer driving a differential piezo.
// Optional PIEZO_SEQ_MUTE_EN adds a mute input that silences the outputs only.
module piezo_seq
    import piezo_seq_pkg::*;
#(
    parameter int FAST_SIM    = 0,
    parameter int NUM_ALERTS  = 3,
    parameter int MAX_NOTES   = 8,
    parameter int REPEAT_CLKS = 150_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_ALERTS-1:0]         alert_req,
`ifdef PIEZO_SEQ_MUTE_EN
    input  logic                          mute,
`endif
    output logic                          piezo,
    output logic                          piezo_n,
    output logic                          busy,
    output logic [$clog2(NUM_ALERTS)-1:0] cur_alert
);

    localparam int AW  = $clog2(NUM_ALERTS);
    localparam int NW  = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    localparam int INC = timer_inc(FAST_SIM);

    state_t          r_state;
    logic [AW-1:0]   r_cur;
    logic [NW-1:0]   r_note;
    logic [DUR_W-1:0] r_dur;
    logic [REP_W-1:0] r_rep;

    note_t           w_note;
    logic            w_req_any;
    logic [AW-1:0]   w_req_low;
    logic            w_preempt;
    logic            w_dur_done;
    logic            w_last_note;
    logic            w_rep_done;
    logic            w_tone;
    logic            w_tone_en;
    logic            w_tone_clr;
    logic            w_drive;

    function automatic int capped_len(input int alert);
        int n;
        n = tune_len(alert);
        if (n > MAX_NOTES) n = MAX_NOTES;
        if (n < 1) n = 1;
        return n;
    endfunction

    always_comb begin
        w_req_any = 1'b0;
        w_req_low = '0;
        for (int i = NUM_ALERTS - 1; i >= 0; i--) begin
            if (alert_req[i]) begin
                w_req_any = 1'b1;
                w_req_low = AW'(i);
            end
        end
    end

    assign w_note      = tune_note(int'(r_cur), int'(r_note));
    assign w_dur_done  = ({1'b0, r_dur} + (DUR_W+1)'(INC)) >= {1'b0, w_note.duration};
    assign w_rep_done  = ({1'b0, r_rep} + (REP_W+1)'(INC)) >= (REP_W+1)'(REPEAT_CLKS);
    assign w_last_note = (int'(r_note) == capped_len(int'(r_cur)) - 1);
    assign w_preempt   = (r_state != ST_IDLE) && w_req_any && (w_req_low < r_cur);

    // Tone restarts low on every tune start, note change and outside PLAY.
    assign w_tone_en  = (r_state == ST_PLAY);
    assign w_tone_clr = (r_state != ST_PLAY) || w_preempt || w_dur_done;

    piezo_tone_gen #(
        .INC(INC)
    ) u_tone (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (w_tone_en),
        .clr        (w_tone_clr),
        .half_period(w_note.half_period),
        .tone       (w_tone)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_note  <= '0;
            r_dur   <= '0;
            r_rep   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_state <= ST_PLAY;
                        r_cur   <= w_req_low;
                        r_note  <= '0;
                        r_dur   <= '0;
                        r_rep   <= '0;
                    end
                end
                ST_PLAY: begin
                    if (w_preempt) begin
                        r_cur  <= w_req_low;
                        r_note <= '0;
                        r_dur  <= '0;
                        r_rep  <= '0;
                    end else begin
                        r_rep <= r_rep + REP_W'(INC);
                        if (w_dur_done) begin
                            r_dur <= '0;
                            if (!w_last_note) begin
                                r_note <= r_note + NW'(1);
                            end else if (alert_req[0]) begin
                                r_cur  <= '0;
                                r_note <= '0;
                                r_rep  <= '0;
                            end else if (w_req_any) begin
                                r_state <= ST_GAP;
                                r_note  <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_cur   <= '0;
                                r_note  <= '0;
                                r_rep   <= '0;
                            end
                        end else begin
                            r_dur <= r_dur + DUR_W'(INC);
                        end
                    end
                end
                ST_GAP: begin
                    if (w_preempt || (w_rep_done && w_req_any)) begin
                        r_state <= ST_PLAY;
                        r_cur   <= w_req_low;
                        r_note  <= '0;
                        r_dur   <= '0;
                        r_rep   <= '0;
                    end else if (w_rep_done) begin
                        r_state <= ST_IDLE;
                        r_cur   <= '0;
                        r_rep   <= '0;
                    end else begin
                        r_rep <= r_rep + REP_W'(INC);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PIEZO_SEQ_MUTE_EN
    assign w_drive = (r_state == ST_PLAY) && !mute;
`else
    assign w_drive = (r_state == ST_PLAY);
`endif

    assign piezo     = w_drive & w_tone;
    assign piezo_n   = w_drive & ~w_tone;
    assign busy      = (r_state != ST_IDLE);
    assign cur_alert = r_cur;

endmodule

// File: doc/piezo_seq.md
PIEZO_SEQ -- requirements
Module: piezo_seq

Interface
REQ-001 Parameter FAST_SIM, default 0: nonzero advances every timer by 64 per clock instead of 1.
REQ-002 Parameter NUM_ALERTS, default 3: number of alert request channels; index 0 is highest priority.
REQ-003 Parameter MAX_NOTES, default 8: tune table depth per alert.
REQ-004 Parameter REPEAT_CLKS, default 150_000_000: tune-start-to-tune-start repeat interval in real clocks.
REQ-005 clk  input  1  system clock; the only clock.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 alert_req  input  NUM_ALERTS  level requests, one per alert.
REQ-008 piezo  output  1  piezo drive, positive leg.
REQ-009 piezo_n  output  1  piezo drive, negative leg.
REQ-010 busy  output  1  high while a tune or repeat gap is in progress.
REQ-011 cur_alert  output  $clog2(NUM_ALERTS)  index of the alert being served; 0 when idle.

Function
REQ-012 States SHALL be IDLE, PLAY and GAP.
REQ-013 IDLE: with any alert_req bit set, the next state SHALL be PLAY with cur_alert = lowest set index, note index 0, and all timers cleared.
REQ-014 PLAY: period_cnt (15b) SHALL add INC (64 or 1) each clock; when period_cnt+INC >= half_period[note], piezo SHALL toggle and period_cnt SHALL clear.
REQ-015 PLAY: dur_cnt (26b) SHALL add INC each clock; when dur_cnt+INC >= duration[note], note index SHALL advance, dur_cnt and period_cnt SHALL clear, and piezo SHALL restart at 0.
REQ-016 After the last note (index == tune_len[cur_alert]-1), alert 0 still requested -> PLAY from note 0 with no gap; else any request -> GAP; none -> IDLE.
REQ-017 rep_cnt (28b) SHALL clear at every tune start and add INC each clock in PLAY and GAP.
REQ-018 GAP: when rep_cnt+INC >= REPEAT_CLKS, the next state SHALL be PLAY with the lowest set request, or IDLE if none.
REQ-019 In PLAY or GAP, a request with index lower than cur_alert SHALL preempt within 1 clock: tune restarts at note 0 for the new alert, all timers cleared.
REQ-020 Deassertion of the current request mid-tune SHALL NOT abort it; the tune completes, then REQ-016 applies.
REQ-021 Simultaneous requests SHALL be resolved by lowest index; ties are impossible.
REQ-022 In PLAY, piezo_n SHALL equal ~piezo; in IDLE and GAP, piezo = 0 and piezo_n = 0.
REQ-023 All counters SHALL saturate-free wrap only via the clears above; compare is >=, so a FAST_SIM overshoot never misses a boundary.

Reset
REQ-024 On rst_n low at a clk edge: state IDLE, all counters 0, note index 0, piezo 0, piezo_n 0, busy 0, cur_alert 0.
REQ-025 Reset mid-tune SHALL abandon the tune; the first request after reset plays immediately, with no gap.

Configuration
REQ-026 Macro PIEZO_SEQ_MUTE_EN, when defined, SHALL add input mute (1b): while high, piezo and piezo_n are forced to 0 but state and timers run unchanged.
REQ-027 Without PIEZO_SEQ_MUTE_EN there SHALL be no mute port and outputs follow REQ-022 only.

Structure
REQ-028 Package piezo_seq_pkg SHALL hold the state enum, the note record type (half_period 15b, duration 26b), per-alert tune tables, tune_len, and fast-sim scaled constants.
REQ-029 Sub-module piezo_tone_gen SHALL implement the period counter and toggle (REQ-014) with inputs en, clr and half_period.

Verification (FAST_SIM=1, NUM_ALERTS=3, REPEAT_CLKS scaled to 2_343_744)
REQ-030 Reset, then alert_req=3'b010 for 1 clk -> PLAY next clk, cur_alert=1, tune plays to completion, then IDLE, busy 0.
REQ-031 alert_req=3'b100 held -> tune plays, GAP, replay starting exactly REPEAT_CLKS/64 clocks after first start.
REQ-032 alert_req=3'b001 held -> back-to-back replays with 0 gap clocks, piezo_n == ~piezo throughout PLAY.
REQ-033 Playing alert 2 at note 3, assert bit 0 -> next clk cur_alert=0, note 0, period_cnt 0.
REQ-034 Note half_period 384 -> piezo toggles every 6 clocks; rst_n low mid-note -> piezo 0, state IDLE next edge.
REQ-035 With PIEZO_SEQ_MUTE_EN, mute=1 during PLAY -> both outputs 0, busy 1, note timing unchanged after release.
